// File: rtl/control_unit_mc.sv
// Multi-cycle decode-stage control unit: decodes scalar, branch and vector
// instructions and sequences multi-beat vector operations while stalling fetch.
module control_unit_mc #(
   parameter int unsigned VEC_BEATS  = 4,
   parameter int unsigned VMEM_BEATS = 4,
   parameter logic [4:0]  PC_REG     = 5'd15,
   parameter int unsigned BEAT_W     = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              InstrValid,
   input  logic              Flush,
   input  logic [5:0]        Opcode,
   input  logic [2:0]        Func,
   input  logic [4:0]        Rd,
   output logic              PCSrc,
   output logic              RegWrite,
   output logic              RegWriteV,
   output logic              MemtoReg,
   output logic              MemWrite,
   output logic              ALUSel,
   output logic              Branch,
   output logic              ALUSrc,
   output logic              MemSrc,
   output logic [2:0]        ALUControl,
   output logic [1:0]        FlagWrite,
   output logic [1:0]        ImmSrc,
   output logic [1:0]        RegSrc,
   output logic [1:0]        MemData,
   output logic [BEAT_W-1:0] Beat,
   output logic              Stuck
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t            state_q, state_d;
   logic [BEAT_W-1:0] counter_q, counter_d;
   logic [5:0]        opcode_q, opcode_d;
   logic [2:0]        func_q, func_d;
   logic [4:0]        rd_q, rd_d;

   logic [5:0]        effOpcode;
   logic [2:0]        effFunc;
   logic [4:0]        effRd;

   logic              decRegWrite, decRegWriteV, decMemWrite, decBranch;
   logic              decMemtoReg, decAluSel, decAluSrc, decMemSrc;
   logic [2:0]        decAluCtrl;
   logic [1:0]        decFlagWrite, decImmSrc, decRegSrc, decMemData;
   logic              isVec, isVmem;

   logic [BEAT_W:0]   beatsN;
   logic              lastBeat;
   logic              enable;
   logic              regWriteG, branchG;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         counter_q <= '0;
         opcode_q  <= '0;
         func_q    <= '0;
         rd_q      <= '0;
      end else begin
         state_q   <= state_d;
         counter_q <= counter_d;
         opcode_q  <= opcode_d;
         func_q    <= func_d;
         rd_q      <= rd_d;
      end
   end

   // While a vector sequence runs, the latched instruction replaces the live inputs.
   assign effOpcode = (state_q == BUSY) ? opcode_q : Opcode;
   assign effFunc   = (state_q == BUSY) ? func_q   : Func;
   assign effRd     = (state_q == BUSY) ? rd_q     : Rd;

   always_comb begin
      decRegWrite  = 1'b0;
      decRegWriteV = 1'b0;
      decMemWrite  = 1'b0;
      decBranch    = 1'b0;
      decMemtoReg  = 1'b0;
      decAluSel    = 1'b0;
      decAluSrc    = 1'b0;
      decMemSrc    = 1'b0;
      decAluCtrl   = 3'b000;
      decFlagWrite = 2'b00;
      decImmSrc    = 2'b00;
      decRegSrc    = 2'b00;
      decMemData   = 2'b00;
      isVec        = 1'b0;
      isVmem       = 1'b0;
      unique case (effOpcode[5:4])
         2'b00: begin
            if (effOpcode[3:2] == 2'b00) begin
               decRegWrite  = 1'b1;
               decAluSrc    = effOpcode[1];
               decAluCtrl   = effFunc;
               decFlagWrite = effOpcode[0] ? 2'b11 : 2'b00;
            end
         end
         2'b01: begin
            if (effOpcode[3:1] == 3'b000) begin
               decAluSrc  = 1'b1;
               decImmSrc  = 2'b01;
               decAluCtrl = 3'b000;
               if (!effOpcode[0]) begin
                  decRegWrite = 1'b1;
                  decMemtoReg = 1'b1;
               end else begin
                  decMemWrite = 1'b1;
                  decRegSrc   = 2'b10;
               end
            end
         end
         2'b10: begin
            decBranch = 1'b1;
            decImmSrc = 2'b10;
            decRegSrc = 2'b01;
         end
         2'b11: begin
            if (!effOpcode[3]) begin
               decRegWriteV = 1'b1;
               decAluSel    = 1'b1;
               decAluCtrl   = effFunc;
               isVec        = 1'b1;
            end else if (effOpcode[2:1] == 2'b00) begin
               isVec     = 1'b1;
               isVmem    = 1'b1;
               decMemSrc = 1'b1;
               if (!effOpcode[0]) begin
                  decRegWriteV = 1'b1;
                  decMemtoReg  = 1'b1;
                  decMemData   = 2'b01;
               end else begin
                  decMemWrite = 1'b1;
                  decMemData  = 2'b10;
                  decRegSrc   = 2'b10;
               end
            end
         end
         default: ;
      endcase
   end

   assign beatsN   = isVmem ? (BEAT_W+1)'(VMEM_BEATS) : (BEAT_W+1)'(VEC_BEATS);
   assign lastBeat = ({1'b0, counter_q} + (BEAT_W+1)'(1)) >= beatsN;

   // Sequencer plus output gating; reset forces every output low combinationally.
   always_comb begin
      state_d   = state_q;
      counter_d = counter_q;
      opcode_d  = opcode_q;
      func_d    = func_q;
      rd_d      = rd_q;
      enable    = 1'b0;
      Stuck     = 1'b0;
      Beat      = '0;
      unique case (state_q)
         IDLE: begin
            enable = InstrValid && !Flush;
            if (enable && isVec && (beatsN > (BEAT_W+1)'(1))) begin
               Stuck     = 1'b1;
               opcode_d  = Opcode;
               func_d    = Func;
               rd_d      = Rd;
               counter_d = BEAT_W'(1);
               state_d   = BUSY;
            end
         end
         BUSY: begin
            Beat = counter_q;
            if (Flush) begin
               state_d   = IDLE;
               counter_d = '0;
            end else begin
               enable = 1'b1;
               if (lastBeat) begin
                  state_d   = IDLE;
                  counter_d = '0;
               end else begin
                  Stuck     = 1'b1;
                  counter_d = counter_q + BEAT_W'(1);
               end
            end
         end
         default: begin
            state_d   = IDLE;
            counter_d = '0;
         end
      endcase

      regWriteG  = decRegWrite & enable;
      branchG    = decBranch & enable;
      RegWrite   = regWriteG;
      Branch     = branchG;
      RegWriteV  = decRegWriteV & enable;
      MemWrite   = decMemWrite & enable;
      FlagWrite  = decFlagWrite & {2{enable}};
      PCSrc      = branchG | (regWriteG & (effRd == PC_REG));
      MemtoReg   = decMemtoReg;
      ALUSel     = decAluSel;
      ALUSrc     = decAluSrc;
      MemSrc     = decMemSrc;
      ALUControl = decAluCtrl;
      ImmSrc     = decImmSrc;
      RegSrc     = decRegSrc;
      MemData    = decMemData;

      if (!rst_n) begin
         RegWrite   = 1'b0;
         Branch     = 1'b0;
         RegWriteV  = 1'b0;
         MemWrite   = 1'b0;
         FlagWrite  = 2'b00;
         PCSrc      = 1'b0;
         MemtoReg   = 1'b0;
         ALUSel     = 1'b0;
         ALUSrc     = 1'b0;
         MemSrc     = 1'b0;
         ALUControl = 3'b000;
         ImmSrc     = 2'b00;
         RegSrc     = 2'b00;
         MemData    = 2'b00;
         Beat       = '0;
         Stuck      = 1'b0;
      end
   end

endmodule

// File: doc/control_unit_mc.md
Name: control_unit_mc

Overview:
- Parametrised multi-cycle successor to the single-cycle control unit in the decode stage.
- Decodes Opcode/Func/Rd into the same datapath control set, with real FlagWrite and PCSrc generation.
- Sequences multi-beat vector instructions (vector ALU and vector memory) with an internal beat counter.
- Drives Stuck to freeze fetch/decode until the final beat issues.

Parameters:
- VEC_BEATS, 4, beats per vector ALU instruction (1..16); 1 means single-cycle.
- VMEM_BEATS, 4, beats per vector load/store (1..16).
- PC_REG, 5'd15, register index whose write redirects the PC.
- BEAT_W, 4, width of Beat output; must satisfy 2^BEAT_W >= max(VEC_BEATS, VMEM_BEATS).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- InstrValid  in  1  decode-stage instruction valid
- Flush  in  1  discard current instruction, including an in-flight vector sequence
- Opcode  in  6  [5:4] class (00 scalar ALU, 01 scalar mem, 10 branch, 11 vector); [3:0] subop
- Func  in  3  ALU function
- Rd  in  5  destination register
- PCSrc, RegWrite, RegWriteV, MemtoReg, MemWrite, ALUSel, Branch, ALUSrc, MemSrc  out  1 each  datapath controls
- ALUControl  out  3  ALU operation
- FlagWrite  out  2  flag-group write enables
- ImmSrc, RegSrc, MemData  out  2 each  immediate, register-source and memory-data selects
- Beat  out  BEAT_W  current vector beat index
- Stuck  out  1  stall fetch/decode

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. While rst_n=0: FSM=IDLE, counter=0, latched instruction=0, all outputs 0.
- Effective instruction: in IDLE, the live inputs; in BUSY, the latched Opcode/Func/Rd.
- Control gating: if InstrValid=0 in IDLE, or Flush=1, all enables (RegWrite, RegWriteV, MemWrite, Branch, PCSrc, FlagWrite) are 0 and Stuck=0. Select outputs then hold their decoded value.
- Decode is combinational; zero added latency.
  - Class 00: RegWrite=1, ALUSrc=Opcode[1], ALUControl=Func, ALUSel=0, FlagWrite=Opcode[0] ? 2'b11 : 2'b00.
  - Class 01: Opcode[0]=0 is load (RegWrite=1, MemtoReg=1); Opcode[0]=1 is store (MemWrite=1, RegWrite=0). ALUSrc=1, ImmSrc=2'b01, ALUControl=3'b000 (add).
  - Class 10: Branch=1, ImmSrc=2'b10, RegWrite=0, FlagWrite=0.
  - Class 11: Opcode[3]=0 is vector ALU (RegWriteV=1, ALUSel=1, ALUControl=Func). Opcode[3]=1 is vector mem: Opcode[0]=0 load (RegWriteV=1, MemtoReg=1, MemSrc=1, MemData=2'b01); Opcode[0]=1 store (MemWrite=1, MemSrc=1, MemData=2'b10).
  - Undefined subops decode as NOP (all enables 0).
- PCSrc = Branch OR (RegWrite AND Rd==PC_REG).
- FSM states: IDLE, BUSY.
  - IDLE with valid vector instruction, N>1 beats, Flush=0: Beat=0, Stuck=1; latch Opcode/Func/Rd; counter<=1; go BUSY.
  - IDLE with N=1, or a non-vector instruction: Stuck=0, Beat=0, stay IDLE.
  - BUSY: Beat=counter; live inputs ignored except Flush. Enables re-asserted every beat. Stuck=1 while counter<N-1.
  - BUSY with counter==N-1: Stuck=0, counter<=0, go IDLE next cycle.
  - Flush in BUSY (any beat): enables 0 that cycle, Stuck=0, go IDLE, counter<=0.
- Beat is 0 in IDLE; it never exceeds N-1.
- Reset asserted mid-sequence: immediate return to IDLE with all outputs 0.

Test Plan:
- Reset: rst_n=0 with Opcode=6'b110000 and InstrValid=1 -> all outputs 0 and Stuck=0, asynchronously before the next clk edge.
- Scalar ALU: Opcode=6'b000011, Func=3'b010, Rd=3 -> RegWrite=1, ALUSrc=1, ALUControl=010, FlagWrite=11, PCSrc=0, Stuck=0. Same with Rd=15 -> PCSrc=1.
- Vector ALU, VEC_BEATS=4: Opcode=6'b110000 held for one cycle then changed to a store -> Beat 0,1,2,3 on four consecutive cycles; RegWriteV=1 on all four; Stuck=1,1,1,0; no MemWrite during the sequence.
- Vector store, VMEM_BEATS=2: Opcode=6'b111001 -> MemWrite=1 for 2 cycles, MemData=10, Stuck=1 then 0, returns to IDLE.
- Flush at beat 2 of a 4-beat vector op -> enables 0 and Stuck=0 that cycle; next cycle decodes the live inputs with Beat=0.
- InstrValid=0 with a branch opcode 6'b100000 -> Branch=0, PCSrc=0, state stays IDLE.
